// File: rtl/iir_sos_cascade.sv
// Cascade of biquad sections sharing one multiply-accumulate unit,
// with valid/ready sample streams and a runtime coefficient bank.
module iir_sos_cascade #(
  parameter int DW   = 24,
  parameter int CW   = 24,
  parameter int FRAC = 22,
  parameter int NSEC = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DW-1:0]               s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DW-1:0]               m_data,
  input  logic                        cfg_we,
  input  logic [$clog2(5*NSEC)-1:0]   cfg_addr,
  input  logic [CW-1:0]               cfg_data,
  output logic                        cfg_ready,
  input  logic [NSEC-1:0]             bypass,
  input  logic                        clr,
  output logic                        busy,
  output logic                        sat_flag
);

  localparam int AW   = $clog2(5*NSEC);
  localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int ACCW = DW + CW + 4;
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC-1);

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  state_t state, state_nx;

  logic signed [CW-1:0]    coef [5*NSEC];
  logic signed [DW-1:0]    x1 [NSEC];
  logic signed [DW-1:0]    x2 [NSEC];
  logic signed [DW-1:0]    y1 [NSEC];
  logic signed [DW-1:0]    y2 [NSEC];
  logic signed [DW-1:0]    xcur;
  logic signed [ACCW-1:0]  acc;
  logic [2:0]              j;
  logic [SW-1:0]           sec;

  logic                    last;
  logic [AW-1:0]           cidx;
  logic signed [DW-1:0]    op;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  prod_x;
  logic signed [ACCW-1:0]  rnd;
  logic signed [ACCW-1:0]  shifted;
  logic [ACCW-DW:0]        hi;
  logic                    clip;
  logic signed [DW-1:0]    ysat;
  logic                    addr_ok;

  assign s_ready   = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last      = (sec == SW'(NSEC-1));
  assign cidx      = AW'(32'(sec) * 5 + 32'(j));
  assign addr_ok   = 32'(cfg_addr) < 32'(5*NSEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (s_valid) state_nx = MAC;
      MAC:     if (j == 3'd4) state_nx = WB;
      WB:      state_nx = last ? OUT : MAC;
      OUT:     if (!m_valid || m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_comb begin
    op = '0;
    unique case (j)
      3'd0:    op = xcur;
      3'd1:    op = x1[sec];
      3'd2:    op = x2[sec];
      3'd3:    op = y1[sec];
      3'd4:    op = y2[sec];
      default: op = '0;
    endcase
  end

  assign prod    = coef[cidx] * op;
  assign prod_x  = ACCW'(prod);
  assign rnd     = acc + HALF;
  assign shifted = rnd >>> FRAC;
  assign hi      = shifted[ACCW-1:DW-1];
  assign clip    = !((&hi) || !(|hi));

  // Clip toward the sign of the full-width result
  always_comb begin
    ysat = shifted[DW-1:0];
    if (clip) ysat = hi[ACCW-DW] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5*NSEC; i++)
        coef[i] <= (i % 5 == 0) ? CW'(1) <<< FRAC : '0;
      for (int k = 0; k < NSEC; k++) begin
        x1[k] <= '0;
        x2[k] <= '0;
        y1[k] <= '0;
        y2[k] <= '0;
      end
      xcur     <= '0;
      acc      <= '0;
      j        <= '0;
      sec      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < NSEC; k++) begin
        x1[k] <= '0;
        x2[k] <= '0;
        y1[k] <= '0;
        y2[k] <= '0;
      end
      acc      <= '0;
      j        <= '0;
      sec      <= '0;
      m_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_we && addr_ok) coef[cfg_addr] <= cfg_data;
          if (s_valid) begin
            xcur <= s_data;
            acc  <= '0;
            j    <= '0;
            sec  <= '0;
          end
        end
        MAC: begin
          acc <= (j < 3'd3) ? acc + prod_x : acc - prod_x;
          j   <= (j == 3'd4) ? 3'd0 : j + 3'd1;
        end
        WB: begin
          acc <= '0;
          j   <= '0;
          sec <= last ? '0 : sec + 1'b1;
          if (!bypass[sec]) begin
            x2[sec] <= x1[sec];
            x1[sec] <= xcur;
            y2[sec] <= y1[sec];
            y1[sec] <= ysat;
            xcur    <= ysat;
            if (clip) sat_flag <= 1'b1;
          end
        end
        OUT: begin
          if (!m_valid || m_ready) begin
            m_data  <= xcur;
            m_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
